// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter that owns the 4:1 mux select pins {s1,s2}.
// The grant is capped at MAX_HOLD cycles whenever another requester is waiting.
module mux_sel_arbiter #(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       s1,
  output logic       s2,
  output logic       busy,
  output logic [1:0] owner
);

  // state | meaning
  // IDLE  | no grant active; select pins keep the last owner
  // GRANT | gnt one-hot for owner; hold_cnt counts ownership cycles
  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  state_t     state, state_nxt;
  logic [3:0] gnt_nxt;
  logic [1:0] owner_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [3:0] hold_cnt, hold_nxt;
  logic [3:0] others;
  logic [2:0] pick_all, pick_oth;
  logic       do_grant;
  logic [1:0] grant_idx;

  // Returns {found, index} of the first set bit searching start, start+1, ... mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] v, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (v[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      owner    <= 2'd0;
      ptr      <= 2'd0;
      hold_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      owner    <= owner_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    do_grant  = 1'b0;
    grant_idx = 2'd0;
    others    = req & ~(4'b0001 << owner);
    pick_all  = rr_pick(req, ptr);
    pick_oth  = rr_pick(others, ptr);

    case (state)
      IDLE: begin
        if (pick_all[2]) begin
          do_grant  = 1'b1;
          grant_idx = pick_all[1:0];
        end
      end
      GRANT: begin
        if (!req[owner]) begin
          if (pick_oth[2]) begin
            do_grant  = 1'b1;
            grant_idx = pick_oth[1:0];
          end else begin
            gnt_nxt   = 4'b0000;
            state_nxt = IDLE;
          end
        end else if (hold_cnt >= HOLD_MAX && pick_oth[2]) begin
          do_grant  = 1'b1;
          grant_idx = pick_oth[1:0];
        end else if (hold_cnt < HOLD_MAX) begin
          hold_nxt = hold_cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Any new ownership restarts the hold count and moves the pointer past the grantee.
    if (do_grant) begin
      state_nxt = GRANT;
      gnt_nxt   = 4'b0001 << grant_idx;
      owner_nxt = grant_idx;
      ptr_nxt   = grant_idx + 2'd1;
      hold_nxt  = 4'd1;
    end
  end

  assign s1   = owner[1];
  assign s2   = owner[0];
  assign busy = |gnt;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: vector table through a scoreboard queue, plus
// hand-written async-reset and MAX_HOLD=1 sequences.
module tb_mux_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, req1;
  logic [3:0] gnt, gnt1;
  logic       s1, s2, busy, s1_1, s2_1, busy1;
  logic [1:0] owner, owner1;

  mux_sel_arbiter #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt),
    .s1(s1), .s2(s2), .busy(busy), .owner(owner)
  );

  mux_sel_arbiter #(.MAX_HOLD(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .gnt(gnt1),
    .s1(s1_1), .s2(s2_1), .busy(busy1), .owner(owner1)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pre_rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void add(input logic pr, input logic [3:0] r,
                              input logic [3:0] g, input logic [1:0] s);
    vec_t v;
    v.pre_rst = pr; v.req = r; v.gnt = g; v.sel = s;
    vecs.push_back(v);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    req  = 4'b0000;
    req1 = 4'b0000;
    rst  = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
  endtask

  // Drive one request vector, queue its expectation, compare after the edge.
  task automatic step(input int which, input logic [3:0] r,
                      input logic [3:0] eg, input logic [1:0] es, input string tag);
    exp_t e;
    exp_t x;
    @(negedge clk);
    if (which == 0) req = r; else req1 = r;
    e.gnt = eg; e.sel = es;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      x = sb.pop_front();
      if (which == 0) begin
        check({tag, "_gnt"},   int'(gnt),        int'(x.gnt));
        check({tag, "_sel"},   int'({s1, s2}),   int'(x.sel));
        check({tag, "_busy"},  int'(busy),       int'(|x.gnt));
        check({tag, "_owner"}, int'(owner),      int'(x.sel));
      end else begin
        check({tag, "_gnt"},   int'(gnt1),       int'(x.gnt));
        check({tag, "_sel"},   int'({s1_1, s2_1}), int'(x.sel));
        check({tag, "_busy"},  int'(busy1),      int'(|x.gnt));
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    req1 = 4'b0000;

    // basic grant and sticky select on release
    add(1'b1, 4'b0001, 4'b0001, 2'd0);
    add(1'b0, 4'b0000, 4'b0000, 2'd0);
    // full contention, MAX_HOLD=4 rotation
    for (int i = 0; i < 17; i++)
      add(i == 0, 4'b1111, 4'b0001 << ((i / 4) % 4), 2'((i / 4) % 4));
    // release handoff with no bubble, then wrap-around
    add(1'b1, 4'b0100, 4'b0100, 2'd2);
    add(1'b0, 4'b1001, 4'b1000, 2'd3);
    add(1'b0, 4'b0001, 4'b0001, 2'd0);
    add(1'b0, 4'b0000, 4'b0000, 2'd0);
    // sole requester saturates, then a newcomer takes over immediately
    for (int i = 0; i < 20; i++)
      add(i == 0, 4'b0010, 4'b0010, 2'd1);
    add(1'b0, 4'b0011, 4'b0001, 2'd0);
    add(1'b0, 4'b0011, 4'b0001, 2'd0);
    // owner 3 active for the async reset sequence
    add(1'b1, 4'b1000, 4'b1000, 2'd3);

    do_reset();
    check("reset_gnt",   int'(gnt),      0);
    check("reset_sel",   int'({s1, s2}), 0);
    check("reset_busy",  int'(busy),     0);
    check("reset_owner", int'(owner),    0);

    foreach (vecs[i]) begin
      if (vecs[i].pre_rst) do_reset();
      step(0, vecs[i].req, vecs[i].gnt, vecs[i].sel, $sformatf("vec%0d", i));
    end

    // asynchronous reset mid-cycle while owner 3 holds the grant
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_gnt",  int'(gnt),      0);
    check("async_rst_sel",  int'({s1, s2}), 0);
    check("async_rst_busy", int'(busy),     0);
    req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    step(0, 4'b1010, 4'b0010, 2'd1, "post_rst");

    // MAX_HOLD=1: contended owner alternates every cycle
    do_reset();
    for (int i = 0; i < 8; i++)
      step(1, 4'b0011, 4'b0001 << (i % 2), 2'(i % 2), $sformatf("mh1_%0d", i));

    if (sb.size() != 0) check("sb_leftover", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
